// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch-stage PC generator: pc_sel encodings
// and mtvec mode values.
package pc_gen_pkg;

  localparam int SEL_PC_WIDTH = 3;

  typedef enum logic [SEL_PC_WIDTH-1:0] {
    SEL_PC_NONE  = 3'd0,
    SEL_PC_ADD4  = 3'd1,
    SEL_PC_JAL   = 3'd2,
    SEL_PC_JALR  = 3'd3,
    SEL_PC_MTVEC = 3'd4,
    SEL_PC_MEPC  = 3'd5
  } sel_pc_e;

  localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC selection: fixed-priority redirect choice, target
// arithmetic, interrupt vectoring and the instruction-alignment check.
module pc_target_calc
  import pc_gen_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int IALIGN      = 4,
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic            taken_i,
  input  sel_pc_e         pc_sel_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic            trap_irq_i,
  input  logic [4:0]      trap_cause_i,
  output logic            is_redirect_o,
  output logic            is_trap_o,
  output logic [XLEN-1:0] target_o,
  output logic            misaligned_o
);

  localparam logic [XLEN-1:0] ALIGN_LSBS = XLEN'(IALIGN - 1);
  localparam logic [XLEN-1:0] BIT0       = XLEN'(1);

  logic [XLEN-1:0] base;
  logic [XLEN-1:0] vec_off;
  logic [XLEN-1:0] jalr_sum;
  logic            flow;

  // Trap returns outrank the branch unit, which outranks decoded jumps.
  always_comb begin
    base          = {mtvec_i[XLEN-1:2], 2'b00};
    vec_off       = {{(XLEN-7){1'b0}}, trap_cause_i, 2'b00};
    jalr_sum      = rs1_i + imm_i;
    is_redirect_o = 1'b1;
    is_trap_o     = 1'b0;
    flow          = 1'b0;
    target_o      = pc_i;
    if (pc_sel_i == SEL_PC_MTVEC) begin
      is_trap_o = 1'b1;
      if (VECTORED_EN && mtvec_i[1:0] == MTVEC_MODE_VECTORED && trap_irq_i)
        target_o = base + vec_off;
      else
        target_o = base;
    end else if (pc_sel_i == SEL_PC_MEPC) begin
      is_trap_o = 1'b1;
      target_o  = mepc_i & ~ALIGN_LSBS;
    end else if (taken_i || pc_sel_i == SEL_PC_JAL) begin
      flow     = 1'b1;
      target_o = pc_i + imm_i;
    end else if (pc_sel_i == SEL_PC_JALR) begin
      flow     = 1'b1;
      target_o = jalr_sum & ~BIT0;
    end else if (pc_sel_i == SEL_PC_ADD4) begin
      is_redirect_o = 1'b0;
      target_o      = pc_i + XLEN'(4);
    end else begin
      is_redirect_o = 1'b0;
    end
    misaligned_o = flow && ((target_o & ALIGN_LSBS) != '0);
  end

endmodule

// File: rtl/pc_gen.sv
// Architectural PC register for the fetch stage; holds through stalls and
// buffers a redirect that arrives while stalled until the stall releases.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              IALIGN       = 4,
  parameter bit              VECTORED_EN  = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            taken,
  input  sel_pc_e         pc_sel,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  input  logic            trap_irq,
  input  logic [4:0]      trap_cause,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            flush,
  output logic            misalign,
  output logic [XLEN-1:0] misalign_va
);

  logic            is_redirect;
  logic            is_trap;
  logic            misaligned;
  logic [XLEN-1:0] target;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
  logic [XLEN-1:0] misalign_va_q, misalign_va_d;
  logic            pc_valid_q;
  logic            pending_q, pending_d;
  logic            flush_q, flush_d;
  logic            misalign_q, misalign_d;

  pc_target_calc #(
    .XLEN        (XLEN),
    .IALIGN      (IALIGN),
    .VECTORED_EN (VECTORED_EN)
  ) u_calc (
    .pc_i          (pc_q),
    .taken_i       (taken),
    .pc_sel_i      (pc_sel),
    .rs1_i         (rs1),
    .imm_i         (imm),
    .mtvec_i       (mtvec),
    .mepc_i        (mepc),
    .trap_irq_i    (trap_irq),
    .trap_cause_i  (trap_cause),
    .is_redirect_o (is_redirect),
    .is_trap_o     (is_trap),
    .target_o      (target),
    .misaligned_o  (misaligned)
  );

  // While a redirect is buffered only trap entry/return may replace it.
  always_comb begin
    pc_d          = pc_q;
    pending_d     = pending_q;
    pend_tgt_d    = pend_tgt_q;
    flush_d       = 1'b0;
    misalign_d    = 1'b0;
    misalign_va_d = misalign_va_q;
    if (stall) begin
      if (pending_q) begin
        if (is_trap) pend_tgt_d = target;
      end else if (misaligned) begin
        misalign_d    = 1'b1;
        misalign_va_d = target;
      end else if (is_redirect) begin
        pending_d  = 1'b1;
        pend_tgt_d = target;
      end
    end else if (pending_q) begin
      pc_d      = is_trap ? target : pend_tgt_q;
      pending_d = 1'b0;
      flush_d   = 1'b1;
    end else if (misaligned) begin
      misalign_d    = 1'b1;
      misalign_va_d = target;
    end else begin
      pc_d    = target;
      flush_d = is_redirect;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_VECTOR;
      pc_valid_q    <= 1'b0;
      pending_q     <= 1'b0;
      pend_tgt_q    <= '0;
      flush_q       <= 1'b0;
      misalign_q    <= 1'b0;
      misalign_va_q <= '0;
    end else begin
      pc_q          <= pc_d;
      pc_valid_q    <= 1'b1;
      pending_q     <= pending_d;
      pend_tgt_q    <= pend_tgt_d;
      flush_q       <= flush_d;
      misalign_q    <= misalign_d;
      misalign_va_q <= misalign_va_d;
    end
  end

  assign pc          = pc_q;
  assign pc_valid    = pc_valid_q;
  assign flush       = flush_q;
  assign misalign    = misalign_q;
  assign misalign_va = misalign_va_q;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: two instances (IALIGN 4 and 2) share one random stimulus
// stream and are compared every cycle against a behavioural model.
module tb_pc_gen;
  import pc_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        taken;
  sel_pc_e     pcSel;
  logic [31:0] rs1;
  logic [31:0] imm;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        trapIrq;
  logic [4:0]  trapCause;

  logic [31:0] pcA, vaA, pcB, vaB;
  logic        validA, flushA, misA, validB, flushB, misB;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mPc[2];
  logic [31:0] mPendTgt[2];
  logic [31:0] mVa[2];
  bit          mValid[2];
  bit          mPend[2];
  bit          mFlush[2];
  bit          mMis[2];

  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h100), .IALIGN(4), .VECTORED_EN(1'b1)) dutA (
    .clk(clk), .rst(rst), .stall(stall), .taken(taken), .pc_sel(pcSel),
    .rs1(rs1), .imm(imm), .mtvec(mtvec), .mepc(mepc), .trap_irq(trapIrq),
    .trap_cause(trapCause), .pc(pcA), .pc_valid(validA), .flush(flushA),
    .misalign(misA), .misalign_va(vaA)
  );

  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h100), .IALIGN(2), .VECTORED_EN(1'b1)) dutB (
    .clk(clk), .rst(rst), .stall(stall), .taken(taken), .pc_sel(pcSel),
    .rs1(rs1), .imm(imm), .mtvec(mtvec), .mepc(mepc), .trap_irq(trapIrq),
    .trap_cause(trapCause), .pc(pcB), .pc_valid(validB), .flush(flushB),
    .misalign(misB), .misalign_va(vaB)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      mPc[k] = 32'h100; mPendTgt[k] = '0; mVa[k] = '0;
      mValid[k] = 0; mPend[k] = 0; mFlush[k] = 0; mMis[k] = 0;
    end
  endtask

  // One clock edge of the PC generator, stated directly from its rules.
  task automatic modelStep(input int k);
    int unsigned ia = (k == 0) ? 4 : 2;
    logic [31:0] tgt;
    logic [31:0] base;
    bit redirect, trapSel, flowSel, bad;
    base = mtvec & 32'hFFFF_FFFC;
    redirect = 1; trapSel = 0; flowSel = 0;
    if (pcSel == SEL_PC_MTVEC) begin
      trapSel = 1;
      tgt = (mtvec[1:0] == 2'b01 && trapIrq) ? base + 4 * trapCause : base;
    end else if (pcSel == SEL_PC_MEPC) begin
      trapSel = 1;
      tgt = mepc - (mepc % ia);
    end else if (taken || pcSel == SEL_PC_JAL) begin
      flowSel = 1;
      tgt = mPc[k] + imm;
    end else if (pcSel == SEL_PC_JALR) begin
      flowSel = 1;
      tgt = (rs1 + imm) & 32'hFFFF_FFFE;
    end else begin
      redirect = 0;
      tgt = (pcSel == SEL_PC_ADD4) ? mPc[k] + 4 : mPc[k];
    end
    bad = flowSel && (tgt % ia != 0);
    mValid[k] = 1; mFlush[k] = 0; mMis[k] = 0;
    if (stall) begin
      if (mPend[k]) begin
        if (trapSel) mPendTgt[k] = tgt;
      end else if (bad) begin
        mMis[k] = 1; mVa[k] = tgt;
      end else if (redirect) begin
        mPend[k] = 1; mPendTgt[k] = tgt;
      end
    end else if (mPend[k]) begin
      mPc[k] = trapSel ? tgt : mPendTgt[k];
      mPend[k] = 0; mFlush[k] = 1;
    end else if (bad) begin
      mMis[k] = 1; mVa[k] = tgt;
    end else begin
      mPc[k] = tgt; mFlush[k] = redirect;
    end
  endtask

  task automatic checkDut(input int k, input logic [31:0] p, input logic v,
                          input logic f, input logic m, input logic [31:0] va);
    checkOutput($sformatf("pc[%0d]@%0t", k, $time), p, mPc[k]);
    checkOutput($sformatf("pc_valid[%0d]@%0t", k, $time), {31'b0, v}, {31'b0, mValid[k]});
    checkOutput($sformatf("flush[%0d]@%0t", k, $time), {31'b0, f}, {31'b0, mFlush[k]});
    checkOutput($sformatf("misalign[%0d]@%0t", k, $time), {31'b0, m}, {31'b0, mMis[k]});
    if (mMis[k]) checkOutput($sformatf("misalign_va[%0d]@%0t", k, $time), va, mVa[k]);
  endtask

  task automatic checkAll();
    checkDut(0, pcA, validA, flushA, misA, vaA);
    checkDut(1, pcB, validB, flushB, misB, vaB);
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    modelStep(0);
    modelStep(1);
    #1;
    checkAll();
  endtask

  task automatic setIdle();
    stall = 0; taken = 0; pcSel = SEL_PC_NONE; rs1 = '0; imm = '0;
    mtvec = '0; mepc = '0; trapIrq = 0; trapCause = '0;
  endtask

  task automatic goTo(input logic [31:0] addr);
    setIdle();
    pcSel = SEL_PC_MTVEC;
    mtvec = addr;
    applyStimulus();
    setIdle();
  endtask

  task automatic pulseReset();
    rst = 1;
    #1;
    modelReset();
    checkAll();
    #1;
    rst = 0;
  endtask

  initial begin
    rst = 1;
    setIdle();
    modelReset();
    #12;
    checkAll();
    checkOutput("t1_rst_pc", pcA, 32'h100);
    checkOutput("t1_rst_valid", {31'b0, validA}, 32'h0);
    rst = 0;

    pcSel = SEL_PC_ADD4;
    applyStimulus();
    checkOutput("t1_pc0", pcA, 32'h104);
    checkOutput("t1_valid", {31'b0, validA}, 32'h1);
    applyStimulus();
    checkOutput("t1_pc1", pcA, 32'h108);
    applyStimulus();
    checkOutput("t1_pc2", pcA, 32'h10C);

    goTo(32'h200);
    taken = 1; imm = 32'hFFFF_FFF8; pcSel = SEL_PC_JALR; rs1 = 32'h40;
    applyStimulus();
    checkOutput("t2_pc", pcA, 32'h1F8);
    checkOutput("t2_flush", {31'b0, flushA}, 32'h1);
    setIdle();
    applyStimulus();
    checkOutput("t2_flush_drop", {31'b0, flushA}, 32'h0);

    for (int variant = 0; variant < 2; variant++) begin
      goTo(32'h300);
      stall = 1; pcSel = SEL_PC_JAL; imm = 32'h20;
      applyStimulus();
      pcSel = SEL_PC_ADD4; imm = '0;
      if (variant == 1) begin
        pcSel = SEL_PC_MTVEC; mtvec = 32'h800;
      end
      for (int c = 0; c < 3; c++) begin
        applyStimulus();
        checkOutput("t3_hold", pcA, 32'h300);
      end
      setIdle();
      applyStimulus();
      checkOutput("t3_release", pcA, (variant == 1) ? 32'h800 : 32'h320);
      checkOutput("t3_flush", {31'b0, flushA}, 32'h1);
    end

    setIdle();
    pcSel = SEL_PC_MTVEC; mtvec = 32'h801; trapIrq = 1; trapCause = 5'd7;
    applyStimulus();
    checkOutput("t5_vectored", pcA, 32'h81C);
    trapIrq = 0;
    applyStimulus();
    checkOutput("t5_direct", pcA, 32'h800);

    goTo(32'h400);
    pcSel = SEL_PC_JAL; imm = 32'h6;
    applyStimulus();
    checkOutput("t6_mis", {31'b0, misA}, 32'h1);
    checkOutput("t6_va", vaA, 32'h406);
    checkOutput("t6_pc_hold", pcA, 32'h400);
    checkOutput("t6_pc_c", pcB, 32'h406);

    goTo(32'h500);
    stall = 1; pcSel = SEL_PC_JAL; imm = 32'h20;
    applyStimulus();
    pulseReset();
    checkOutput("t6_rst_pc", pcA, 32'h100);
    checkOutput("t6_rst_flush", {31'b0, flushA}, 32'h0);
    setIdle();
    applyStimulus();
    checkOutput("t6_lost_pc", pcA, 32'h100);
    checkOutput("t6_lost_flush", {31'b0, flushA}, 32'h0);

    for (int n = 0; n < 3000; n++) begin
      stall     = ($urandom_range(0, 99) < 30);
      taken     = ($urandom_range(0, 99) < 20);
      pcSel     = sel_pc_e'($urandom_range(0, 5));
      imm       = $urandom_range(0, 127) - 64;
      rs1       = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 32'hFFFF);
      mtvec     = $urandom;
      mepc      = $urandom;
      trapIrq   = $urandom_range(0, 1);
      trapCause = 5'($urandom_range(0, 31));
      applyStimulus();
      if ($urandom_range(0, 199) == 0) pulseReset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
